// File: rtl/tlul_arb_pkg.sv
// rtl/tlul_arb_pkg.sv - arbiter state encoding and width helpers
package tlul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  // Width of a host index; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width, wide enough to hold TIMEOUT itself.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structs and opcodes shared by hosts, arbiter and devices
package tlul_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb_if.sv
// rtl/tlul_host_arb_if.sv - host-side and device-side TL-UL bundle around the arbiter
interface tlul_host_arb_if
  import tlul_pkg::*;
#(
  parameter int unsigned NUM = 2
);

  tl_h2d_t [NUM-1:0] tl_h_i;
  tl_d2h_t [NUM-1:0] tl_h_o;
  tl_h2d_t           tl_d_o;
  tl_d2h_t           tl_d_i;

  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );

  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: lowest requester at or above ptr, with wrap
module rr_arbiter
  import tlul_arb_pkg::*;
#(
  parameter int unsigned NUM = 2,
  localparam int unsigned IW = idx_w(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_valid
);

  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    sum       = '0;
    idx       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = NUM - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(NUM)) begin
        sum = sum - (IW + 1)'(NUM);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// rtl/tlul_host_arb.sv - shares one TL-UL device among NUM hosts, one outstanding transaction,
// with a response watchdog that answers the host with an error if the device stays silent
module tlul_host_arb
  import tlul_pkg::*;
  import tlul_arb_pkg::*;
#(
  parameter int unsigned NUM     = 2,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned IW     = idx_w(NUM)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tlul_host_arb_if.slave bus,
  output logic [IW-1:0]  grant_o,
  output logic           busy_o,
  output logic           timeout_o,
  output logic           spurious_o
);

  localparam int unsigned CW = cnt_w(TIMEOUT);

  arb_state_e        state_q;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [7:0]        src_q;
  logic [1:0]        size_q;
  logic              timeout_q;
  logic              spurious_q;

  logic [NUM-1:0]    req_vec;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_valid;
  logic [IW-1:0]     next_ptr;
  tl_h2d_t           req_sel;
  tl_d2h_t [NUM-1:0] h_rsp;
  tl_h2d_t           d_req;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM; i++) begin
      req_vec[i] = bus.tl_h_i[i].a_valid;
    end
  end

  rr_arbiter #(
    .NUM (NUM)
  ) u_rr_arbiter (
    .req       (req_vec),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_sel  = bus.tl_h_i[grant_q];
  assign next_ptr = (grant_q == IW'(NUM - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      src_q      <= '0;
      size_q     <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE && bus.tl_d_i.d_valid) begin
        spurious_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            grant_q <= gnt_idx;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (req_sel.a_valid && bus.tl_d_i.a_ready) begin
            op_q    <= req_sel.a_opcode;
            src_q   <= req_sel.a_source;
            size_q  <= req_sel.a_size;
            cnt_q   <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          // A handshake in the would-be timeout cycle wins over the watchdog.
          if (bus.tl_d_i.d_valid && req_sel.d_ready) begin
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= ERR;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERR: begin
          if (req_sel.d_ready) begin
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    h_rsp = '0;
    d_req = '0;
    unique case (state_q)
      IDLE: begin
        d_req.d_ready = 1'b1;
      end
      ADDR: begin
        d_req                  = req_sel;
        h_rsp[grant_q].a_ready = bus.tl_d_i.a_ready;
      end
      RESP: begin
        d_req                  = req_sel;
        d_req.a_valid          = 1'b0;
        h_rsp[grant_q]         = bus.tl_d_i;
        h_rsp[grant_q].a_ready = 1'b0;
      end
      ERR: begin
        h_rsp[grant_q].d_valid  = 1'b1;
        h_rsp[grant_q].d_error  = 1'b1;
        h_rsp[grant_q].d_source = src_q;
        h_rsp[grant_q].d_size   = size_q;
        h_rsp[grant_q].d_opcode = (op_q == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
      end
      default: begin
        d_req.d_ready = 1'b1;
      end
    endcase
  end

  assign bus.tl_h_o = h_rsp;
  assign bus.tl_d_o = d_req;

  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);
  assign timeout_o  = timeout_q;
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_tlul_host_arb.sv
// tb/tb_tlul_host_arb.sv - directed self-checking bench for tlul_host_arb (NUM=3, TIMEOUT=8)
module tb_tlul_host_arb;
  import tlul_pkg::*;

  logic       clk_i;
  logic       rst_i;
  logic [1:0] grant_o;
  logic       busy_o;
  logic       timeout_o;
  logic       spurious_o;

  int n_checks = 0;
  int n_errors = 0;

  tl_h2d_t d_idle;
  tl_d2h_t e_rsp;

  tlul_host_arb_if #(.NUM(3)) bus ();

  tlul_host_arb #(
    .NUM     (3),
    .TIMEOUT (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .spurious_o (spurious_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    d_idle         = '0;
    d_idle.d_ready = 1'b1;
    rst_i          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.tl_h_i[i]         = '0;
      bus.tl_h_i[i].d_ready = 1'b1;
    end
    bus.tl_d_i         = '0;
    bus.tl_d_i.a_ready = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("rst_busy", 256'(busy_o), 256'(1'b0));
    check("rst_timeout", 256'(timeout_o), 256'(1'b0));
    check("rst_spurious", 256'(spurious_o), 256'(1'b0));
    check("rst_grant", 256'(grant_o), 256'(2'd0));
    check("rst_h_o", 256'(bus.tl_h_o), 256'(0));
    check("rst_d_o", 256'(bus.tl_d_o), 256'(d_idle));
    tick();
    rst_i = 1'b0;

    // All hosts request continuously: grant order 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) begin
      bus.tl_h_i[i].a_valid  = 1'b1;
      bus.tl_h_i[i].a_opcode = PUT_FULL_DATA;
      bus.tl_h_i[i].a_source = 8'h10 + 8'(i);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk_i);
      check("rr_grant", 256'(grant_o), 256'(k % 3));
      check("rr_src", 256'(bus.tl_d_o.a_source), 256'(8'h10 + 8'(k % 3)));
      tick();
      bus.tl_d_i.d_valid = 1'b1;
      @(negedge clk_i);
      check("rr_dvalid", 256'(bus.tl_h_o[k % 3].d_valid), 256'(1'b1));
      tick();
      bus.tl_d_i.d_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) bus.tl_h_i[i].a_valid = 1'b0;

    // Single host 1, Get, zero-wait device
    bus.tl_h_i[1].a_valid   = 1'b1;
    bus.tl_h_i[1].a_opcode  = GET;
    bus.tl_h_i[1].a_source  = 8'h11;
    bus.tl_h_i[1].a_size    = 2'd2;
    bus.tl_h_i[1].a_address = 32'h100;
    @(negedge clk_i);
    check("s_idle_busy", 256'(busy_o), 256'(1'b0));
    check("s_idle_h_o", 256'(bus.tl_h_o), 256'(0));
    tick();
    @(negedge clk_i);
    check("s_grant", 256'(grant_o), 256'(2'd1));
    check("s_d_avalid", 256'(bus.tl_d_o.a_valid), 256'(1'b1));
    check("s_d_addr", 256'(bus.tl_d_o.a_address), 256'(32'h100));
    check("s_h1_aready", 256'(bus.tl_h_o[1].a_ready), 256'(1'b1));
    check("s_h0_aready", 256'(bus.tl_h_o[0].a_ready), 256'(1'b0));
    tick();
    bus.tl_h_i[1].a_valid = 1'b0;
    bus.tl_d_i.d_valid    = 1'b1;
    bus.tl_d_i.d_opcode   = ACCESS_ACK_DATA;
    bus.tl_d_i.d_data     = 32'hdeadbeef;
    bus.tl_d_i.d_source   = 8'h11;
    bus.tl_d_i.d_size     = 2'd2;
    @(negedge clk_i);
    check("s_h1_dvalid", 256'(bus.tl_h_o[1].d_valid), 256'(1'b1));
    check("s_h1_data", 256'(bus.tl_h_o[1].d_data), 256'(32'hdeadbeef));
    check("s_h1_aready_resp", 256'(bus.tl_h_o[1].a_ready), 256'(1'b0));
    check("s_d_avalid_resp", 256'(bus.tl_d_o.a_valid), 256'(1'b0));
    check("s_h0_dvalid", 256'(bus.tl_h_o[0].d_valid), 256'(1'b0));
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    @(negedge clk_i);
    check("s_busy_done", 256'(busy_o), 256'(1'b0));

    // Device stalls a_ready for 5 cycles; ptr is now 2 so host 2 wins over host 0
    bus.tl_d_i.a_ready    = 1'b0;
    bus.tl_h_i[0].a_valid = 1'b1;
    bus.tl_h_i[2].a_valid = 1'b1;
    tick();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_i);
      check("st_grant", 256'(grant_o), 256'(2'd2));
      check("st_h0_aready", 256'(bus.tl_h_o[0].a_ready), 256'(1'b0));
      check("st_h2_aready", 256'(bus.tl_h_o[2].a_ready), 256'(1'b0));
      tick();
    end
    bus.tl_d_i.a_ready = 1'b1;
    @(negedge clk_i);
    check("st_h2_go", 256'(bus.tl_h_o[2].a_ready), 256'(1'b1));
    check("st_h0_still", 256'(bus.tl_h_o[0].a_ready), 256'(1'b0));
    tick();
    bus.tl_h_i[2].a_valid = 1'b0;
    bus.tl_d_i.d_valid    = 1'b1;
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    tick();
    @(negedge clk_i);
    check("st_next_grant", 256'(grant_o), 256'(2'd0));
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    bus.tl_d_i.d_valid    = 1'b1;
    tick();
    bus.tl_d_i.d_valid = 1'b0;

    // Watchdog: host 0 Put, device silent
    bus.tl_h_i[0].a_valid  = 1'b1;
    bus.tl_h_i[0].a_opcode = PUT_FULL_DATA;
    bus.tl_h_i[0].a_source = 8'h5a;
    bus.tl_h_i[0].a_size   = 2'd2;
    bus.tl_d_i.d_error     = 1'b0;
    tick();
    tick();
    bus.tl_h_i[0].a_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      check("to_quiet", 256'(timeout_o), 256'(1'b0));
      tick();
    end
    e_rsp          = '0;
    e_rsp.d_valid  = 1'b1;
    e_rsp.d_opcode = ACCESS_ACK;
    e_rsp.d_error  = 1'b1;
    e_rsp.d_source = 8'h5a;
    e_rsp.d_size   = 2'd2;
    @(negedge clk_i);
    check("to_pulse", 256'(timeout_o), 256'(1'b1));
    check("to_err_rsp", 256'(bus.tl_h_o[0]), 256'(e_rsp));
    check("to_d_o", 256'(bus.tl_d_o), 256'(0));
    check("to_busy", 256'(busy_o), 256'(1'b1));
    tick();
    @(negedge clk_i);
    check("to_pulse_end", 256'(timeout_o), 256'(1'b0));
    check("to_idle", 256'(busy_o), 256'(1'b0));
    tick();
    tick();
    tick();
    bus.tl_d_i.d_valid = 1'b1;
    @(negedge clk_i);
    check("sp_not_fwd", 256'(bus.tl_h_o[0].d_valid), 256'(1'b0));
    check("sp_drain", 256'(bus.tl_d_o.d_ready), 256'(1'b1));
    check("sp_before", 256'(spurious_o), 256'(1'b0));
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    @(negedge clk_i);
    check("sp_set", 256'(spurious_o), 256'(1'b1));

    // Device answers in the exact timeout cycle: normal completion
    bus.tl_h_i[1].a_valid  = 1'b1;
    bus.tl_h_i[1].a_opcode = GET;
    bus.tl_h_i[1].a_source = 8'h33;
    bus.tl_h_i[1].a_size   = 2'd1;
    tick();
    tick();
    bus.tl_h_i[1].a_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      check("edge_quiet", 256'(timeout_o), 256'(1'b0));
      tick();
    end
    bus.tl_d_i.d_valid  = 1'b1;
    bus.tl_d_i.d_error  = 1'b1;
    bus.tl_d_i.d_opcode = ACCESS_ACK_DATA;
    bus.tl_d_i.d_source = 8'h33;
    bus.tl_d_i.d_size   = 2'd1;
    @(negedge clk_i);
    check("edge_dvalid", 256'(bus.tl_h_o[1].d_valid), 256'(1'b1));
    check("edge_derror", 256'(bus.tl_h_o[1].d_error), 256'(1'b1));
    check("edge_src", 256'(bus.tl_h_o[1].d_source), 256'(8'h33));
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    bus.tl_d_i.d_error = 1'b0;
    @(negedge clk_i);
    check("edge_no_timeout", 256'(timeout_o), 256'(1'b0));
    check("edge_idle", 256'(busy_o), 256'(1'b0));
    check("edge_sticky", 256'(spurious_o), 256'(1'b1));

    // Asynchronous reset while in RESP
    bus.tl_h_i[2].a_valid = 1'b1;
    tick();
    tick();
    bus.tl_h_i[2].a_valid = 1'b0;
    @(negedge clk_i);
    check("ar_busy_pre", 256'(busy_o), 256'(1'b1));
    check("ar_grant_pre", 256'(grant_o), 256'(2'd2));
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_busy", 256'(busy_o), 256'(1'b0));
    check("ar_grant", 256'(grant_o), 256'(2'd0));
    check("ar_spurious", 256'(spurious_o), 256'(1'b0));
    check("ar_d_o", 256'(bus.tl_d_o), 256'(d_idle));
    check("ar_h_o", 256'(bus.tl_h_o), 256'(0));
    tick();
    rst_i = 1'b0;
    bus.tl_d_i.d_valid = 1'b1;
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    @(negedge clk_i);
    check("ar_late_spurious", 256'(spurious_o), 256'(1'b1));
    bus.tl_h_i[1].a_valid = 1'b1;
    bus.tl_h_i[2].a_valid = 1'b1;
    tick();
    @(negedge clk_i);
    check("ar_ptr_restart", 256'(grant_o), 256'(2'd1));
    bus.tl_h_i[1].a_valid = 1'b0;
    bus.tl_h_i[2].a_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

Round-robin arbiter that shares one TL-UL device port among `NUM` TL-UL hosts, allowing one outstanding transaction at a time. It sits between several bus masters (e.g. CPU data port and a DMA/capture engine) and the address-decoding mux in front of the peripherals. A response-timeout watchdog synthesizes an error response so a silent device cannot hang a host.

## Interface
Parameters:
- `NUM`, 2: number of host ports, 2..16.
- `TIMEOUT`, 1024: cycles allowed in RESP before an error response is generated; 0 disables the watchdog.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `tl_h_i`  in  `tlul_pkg::tl_h2d_t [NUM-1:0]`  requests from hosts.
- `tl_h_o`  out  `tlul_pkg::tl_d2h_t [NUM-1:0]`  responses to hosts.
- `tl_d_o`  out  `tlul_pkg::tl_h2d_t`  request to the shared device.
- `tl_d_i`  in  `tlul_pkg::tl_d2h_t`  response from the shared device.
- `grant_o`  out  `$clog2(NUM)`  index of the currently or last granted host.
- `busy_o`  out  1  high whenever state is not IDLE.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.
- `spurious_o`  out  1  sticky; set when the device returns `d_valid` in IDLE; cleared only by reset.

## Operation
- The FSM has four states: IDLE, ADDR, RESP and ERR.
- **IDLE**
  - `tl_d_o = '0` except `d_ready=1`, so stray responses are drained.
  - All `tl_h_o = '0`.
  - If any `tl_h_i[i].a_valid` is high, the round-robin pick is registered into `grant_q` and the FSM moves to ADDR.
  - Priority starts at `ptr_q` and searches upward with wrap.
- **ADDR**
  - `tl_d_o = tl_h_i[grant_q]`.
  - `tl_h_o[grant_q].a_ready = tl_d_i.a_ready`; all other `tl_h_o` fields are 0.
  - On `a_valid & a_ready`, capture `a_opcode`, `a_source` and `a_size`, then go to RESP.
- **RESP**
  - `tl_d_o = tl_h_i[grant_q]` with `a_valid` forced to 0.
  - `tl_h_o[grant_q] = tl_d_i` with `a_ready` forced to 0.
  - On `d_valid & d_ready`, go to IDLE and set `ptr_q = grant_q+1` (wrapping at `NUM`).
- **Watchdog (RESP only)**
  - A counter clears on entry to RESP and increments each RESP cycle.
  - When `TIMEOUT != 0` and the count reaches `TIMEOUT-1` without a handshake: pulse `timeout_o` and go to ERR.
- **ERR**
  - `tl_h_o[grant_q]`: `d_valid=1`, `d_error=1`, captured `d_source`/`d_size`, `d_data=0`.
  - `d_opcode` is AccessAckData if the captured opcode was Get, else AccessAck.
  - Device-side `tl_d_o = '0`.
  - On host `d_ready`, update `ptr_q` as in RESP and go to IDLE.
  - A late device response arrives in IDLE and is drained, setting `spurious_o`.
- Non-granted hosts always see `a_ready=0` and `d_valid=0`.
- A host's `a_valid` may be held across the whole IDLE→ADDR sequence; no request is dropped.
- `grant_o = grant_q`.

## Timing
- **Reset values:** state IDLE, `grant_q=0`, `ptr_q=0`, counter 0. Outputs: `busy_o=0`, `timeout_o=0`, `spurious_o=0`, all `tl_h_o='0`, `tl_d_o='0` except `d_ready=1`.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at cycle N is presented to the device at N+1.
- **Minimum transaction:** 3 cycles with a zero-wait device (IDLE, ADDR, RESP). This gives at most one transaction per 3 cycles.
- **Simultaneous requests:** the lowest index at or above `ptr_q`, with wrap, wins.
- **Timeout:** fires on the cycle when the counter reaches `TIMEOUT-1`. A device `d_valid` in that same cycle has priority: it completes normally and no timeout fires.
- **Reset mid-transaction:** returns to the reset state immediately. The in-flight response is later drained as spurious.
- **Counter width:** `$clog2(TIMEOUT+1)`, saturating. No wrap is possible.

## Structure
- Package `tlul_arb_pkg`:
  - `arb_state_e` enum (IDLE, ADDR, RESP, ERR).
  - Localparam helper for the index width.
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: `req[NUM-1:0]`, `ptr`.
  - Outputs: `gnt_idx`, `gnt_valid`.
  - Reusable by other shared-resource arbiters.

## Test plan
- **Single host, zero-wait device:** host 1 issues a Get. Device sees `a_valid` at cycle 1 and responds at cycle 2. Host 1 gets `d_valid` at cycle 2; `busy_o` is 0 at cycle 3.
- **All hosts request continuously (`NUM=3`):** grant order is 0,1,2,0,1,2.
- **Device stalls `a_ready` for 5 cycles:** the other host's `a_ready` stays 0 throughout. Grant is unchanged until the handshake.
- **`TIMEOUT=8`, device silent after an accepted Put from host 0:**
  - `timeout_o` pulses 8 cycles after RESP entry.
  - Host 0 receives AccessAck with `d_error=1` and the original `a_source`.
  - A device response 4 cycles later sets `spurious_o`.
- **Device `d_valid` in the exact timeout cycle:** normal completion, no `timeout_o`, `d_error` passes through from the device.
- **`rst_i` asserted in RESP:** all outputs return to reset values in the same cycle, asynchronously. The next request is granted starting from host 0.
